// File: rtl/sysbus_mem_responder.sv
// Sysbus responder: services tagged read/write requests from an internal word memory.
// Reads return as 8-beat critical-word-first line bursts after a programmable latency.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int RESP_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam logic [BUS_DATA_WIDTH-1:0] MEM_BYTES = BUS_DATA_WIDTH'(MEM_WORDS) << 3;

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [2:0]                beat;
  logic [7:0]                lat_cnt;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                      in_range;
  logic                      is_write;
  logic                      req_xfer;
  logic                      wr_en;
  logic [2:0]                rd_beat;
  logic [WORD_AW-1:0]        rd_idx;
  logic [WORD_AW-1:0]        wr_idx;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  assign in_range = addr_q < MEM_BYTES;
  assign is_write = tag_q[BUS_TAG_WIDTH-1];
  assign req_xfer = bus_reqcyc && bus_reqack;

  // Word within the line wraps mod 8; the line itself comes from the upper address bits.
  assign rd_beat = (state == RESP) ? beat + 3'd1 : 3'd0;
  assign rd_idx  = {addr_q[WORD_AW+2:6], addr_q[5:3] + rd_beat};
  assign wr_idx  = {addr_q[WORD_AW+2:6], addr_q[5:3] + beat};
  assign rd_word = mem[rd_idx];
  assign wr_en   = !reset && (state == WDATA) && req_xfer && in_range;

  // NOTE: the backing store is deliberately left out of reset so its contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus_req;
  end

  // NOTE: every register here uses <= so each branch reads the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // One-cycle ack pulse per beat: drops on the transfer edge.
          bus_reqack <= bus_reqcyc && !bus_reqack;
          if (req_xfer) begin
            addr_q  <= bus_req;
            tag_q   <= bus_reqtag;
            beat    <= '0;
            lat_cnt <= '0;
            state   <= bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : WAIT;
          end
        end
        WDATA: begin
          bus_reqack <= bus_reqcyc && !bus_reqack;
          if (req_xfer) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 8'(RESP_LATENCY)) begin
            state       <= RESP;
            lat_cnt     <= '0;
            bus_respcyc <= 1'b1;
            bus_resptag <= tag_q;
            bus_resp    <= (is_write || !in_range) ? '0 : rd_word;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus_respack) begin
            if (is_write || beat == 3'd7) begin
              state       <= IDLE;
              bus_respcyc <= 1'b0;
              beat        <= '0;
            end else begin
              beat     <= beat + 3'd1;
              bus_resp <= in_range ? rd_word : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomized bench for sysbus_mem_responder against an array-based memory model
// that computes burst order and latency directly from the bus rules.
module tb_sysbus_mem_responder;
  localparam int MEM_WORDS = 4096;
  localparam int LAT       = 4;
  localparam int TMO       = 600;
  localparam longint unsigned MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .MEM_WORDS     (MEM_WORDS),
    .RESP_LATENCY  (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_reqack (bus_reqack),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_seen = 0;

  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] wbuf [8];

  // Each reqack pulse is one cycle wide, so high samples equal pulses.
  always @(negedge clk) if (bus_reqack === 1'b1) ack_seen <= ack_seen + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int model_index(input logic [63:0] addr, input int i);
    longint unsigned w;
    w = (addr / 64) * 8 + ((addr / 8) % 8 + longint'(i)) % 8;
    return int'(w);
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] addr, input int i);
    if (addr >= MEM_BYTES) return 64'h0;
    return model_mem[model_index(addr, i)];
  endfunction

  // Called on a falling edge; returns on the falling edge after the beat transferred.
  task automatic send_beat(input logic [63:0] data, input logic [12:0] tag);
    int n;
    n = 0;
    bus_reqcyc = 1'b1;
    bus_req    = data;
    bus_reqtag = tag;
    do begin
      @(negedge clk);
      n++;
    end while (bus_reqack !== 1'b1 && n < TMO);
    check("reqack", {63'h0, bus_reqack}, 64'h1);
    @(negedge clk);
    bus_reqcyc = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int lat;
    lat = 0;
    while (bus_respcyc !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(LAT + 1));
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [11:0] opaque, input int gap);
    logic [12:0] tag;
    int snap;
    tag = {1'b1, opaque};
    bus_respack = 1'b1;
    send_beat(addr, tag);
    snap = ack_seen;
    for (int i = 0; i < 8; i++) begin
      send_beat(wbuf[i], tag);
      if (addr < MEM_BYTES) model_mem[model_index(addr, i)] = wbuf[i];
      if (i < 7) for (int g = 0; g < gap; g++) @(negedge clk);
    end
    check("wr_acks", 64'(ack_seen - snap), 64'd8);
    wait_resp("wr");
    check("wr_resp", bus_resp, 64'h0);
    check("wr_tag", 64'(bus_resptag), 64'(tag));
    @(negedge clk);
    check("wr_end", {63'h0, bus_respcyc}, 64'h0);
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [11:0] opaque,
                           input int stall_beat, input int stall_len, input string name);
    logic [12:0] tag;
    logic [63:0] e;
    tag = {1'b0, opaque};
    bus_respack = 1'b1;
    send_beat(addr, tag);
    wait_resp(name);
    for (int i = 0; i < 8; i++) begin
      e = exp_word(addr, i);
      check({name, "_cyc"}, {63'h0, bus_respcyc}, 64'h1);
      check({name, "_data"}, bus_resp, e);
      check({name, "_tag"}, 64'(bus_resptag), 64'(tag));
      if (i == stall_beat) begin
        bus_respack = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          check({name, "_hold_cyc"}, {63'h0, bus_respcyc}, 64'h1);
          check({name, "_hold_data"}, bus_resp, e);
          check({name, "_hold_tag"}, 64'(bus_resptag), 64'(tag));
        end
        bus_respack = 1'b1;
      end
      @(negedge clk);
    end
    check({name, "_end"}, {63'h0, bus_respcyc}, 64'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_reqack", {63'h0, bus_reqack}, 64'h0);
    check("rst_respcyc", {63'h0, bus_respcyc}, 64'h0);
    check("rst_resp", bus_resp, 64'h0);
    check("rst_resptag", 64'(bus_resptag), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Fill every line; line 1 (bytes 0x40..0x7F) holds word index as data.
    for (int l = 0; l < MEM_WORDS / 8; l++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = (l == 1) ? 64'(8 + j) : {$urandom, $urandom};
      write_line(64'(l) * 64, 12'($urandom), 0);
    end

    read_line(64'h40, 12'h005, -1, 0, "rd40");
    read_line(64'h68, 12'h0A1, -1, 0, "rd68");

    for (int j = 0; j < 8; j++) wbuf[j] = 64'hA0 + 64'(j);
    write_line(64'h100, 12'h003, 1);
    read_line(64'h100, 12'h007, -1, 0, "rd100");

    read_line(64'h1D8, 12'h0C3, 3, 5, "stall");

    read_line(64'(MEM_BYTES), 12'h0F0, -1, 0, "oob_rd");
    for (int j = 0; j < 8; j++) wbuf[j] = {$urandom, $urandom};
    write_line(64'(MEM_BYTES), 12'h0F1, 0);
    for (int l = 0; l < MEM_WORDS / 8; l++) read_line(64'(l) * 64, 12'(l), -1, 0, "scan");

    // Reset while beat 4 of a read burst is on the bus.
    bus_respack = 1'b1;
    send_beat(64'h1C0, 13'h0033);
    wait_resp("rst_rd");
    for (int i = 0; i < 4; i++) begin
      check("rst_rd_data", bus_resp, exp_word(64'h1C0, i));
      @(negedge clk);
    end
    check("rst_rd_beat4", bus_resp, exp_word(64'h1C0, 4));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_respcyc", {63'h0, bus_respcyc}, 64'h0);
    check("midrst_reqack", {63'h0, bus_reqack}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    read_line(64'h1C0, 12'h034, -1, 0, "post_rst");

    for (int n = 0; n < 150; n++) begin
      logic [63:0] a;
      int kind;
      int sb;
      kind = int'($urandom_range(0, 15));
      a = 64'($urandom_range(0, int'(MEM_BYTES - 1)));
      if (kind == 0) a = 64'(MEM_BYTES) + 64'($urandom_range(0, 4095));
      if (kind == 1) a = {$urandom, $urandom} | (64'h1 << 63);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 8; j++) wbuf[j] = {$urandom, $urandom};
        write_line(a, 12'($urandom), int'($urandom_range(0, 2)));
      end else begin
        sb = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 7));
        read_line(a, 12'($urandom), sb, int'($urandom_range(1, 4)), "rand_rd");
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
